// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate extender: combinational format decode captured into a
// two-entry valid/ready skid buffer (main M drives out_*, skid K absorbs stalls).
module imm_ext_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_U   = 3'b001,
    FMT_S   = 3'b010,
    FMT_B   = 3'b011,
    FMT_J   = 3'b100,
    FMT_IU  = 3'b101,
    FMT_Z   = 3'b110,
    FMT_ILL = 3'b111
  } fmt_e;

  fmt_e             fmt;
  logic [31:7]      ins;
  logic [31:0]      imm32;
  logic             new_ill;
  logic [XLEN-1:0]  new_imm;

  assign ins = in_instr;
  assign fmt = fmt_e'(in_imm_src);

  always_comb begin
    imm32   = '0;
    new_ill = 1'b0;
    case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_IU:  imm32 = {20'b0, ins[31:20]};
      FMT_Z:   imm32 = {27'b0, ins[19:15]};
      FMT_ILL: new_ill = 1'b1;
      default: new_ill = 1'b1;
    endcase
  end

  // Zero-extended formats leave imm32[31] clear, so one sign-extension covers all.
  if (XLEN > 32) begin : g_wide
    assign new_imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign new_imm = imm32;
  end

  logic             m_valid_q, m_valid_d;
  logic [XLEN-1:0]  m_imm_q,   m_imm_d;
  logic [TAG_W-1:0] m_tag_q,   m_tag_d;
  logic             m_ill_q,   m_ill_d;
  logic             k_valid_q, k_valid_d;
  logic [XLEN-1:0]  k_imm_q,   k_imm_d;
  logic [TAG_W-1:0] k_tag_q,   k_tag_d;
  logic             k_ill_q,   k_ill_d;
  logic             rdy_q,     rdy_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             accept, pop;

  assign accept = in_valid & rdy_q;
  assign pop    = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_tag_d   = m_tag_q;
    m_ill_d   = m_ill_q;
    k_valid_d = k_valid_q;
    k_imm_d   = k_imm_q;
    k_tag_d   = k_tag_q;
    k_ill_d   = k_ill_q;
    cnt_d     = cnt_q;
    if (pop) begin
      if (k_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = k_imm_q;
        m_tag_d   = k_tag_q;
        m_ill_d   = k_ill_q;
        k_valid_d = accept;
        if (accept) begin
          k_imm_d = new_imm;
          k_tag_d = in_tag;
          k_ill_d = new_ill;
        end
      end else begin
        m_valid_d = accept;
        if (accept) begin
          m_imm_d = new_imm;
          m_tag_d = in_tag;
          m_ill_d = new_ill;
        end
      end
    end else if (accept) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = new_imm;
        m_tag_d   = in_tag;
        m_ill_d   = new_ill;
      end else begin
        k_valid_d = 1'b1;
        k_imm_d   = new_imm;
        k_tag_d   = in_tag;
        k_ill_d   = new_ill;
      end
    end
    if (accept && new_ill && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered ready: reflects next-cycle skid occupancy, held low during reset.
    rdy_d = ~k_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_tag_q   <= '0;
      m_ill_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_imm_q   <= '0;
      k_tag_q   <= '0;
      k_ill_q   <= 1'b0;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_tag_q   <= m_tag_d;
      m_ill_q   <= m_ill_d;
      k_valid_q <= k_valid_d;
      k_imm_q   <= k_imm_d;
      k_tag_q   <= k_tag_d;
      k_ill_q   <= k_ill_d;
      rdy_q     <= rdy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = m_valid_q;
  assign out_imm     = m_imm_q;
  assign out_tag     = m_tag_q;
  assign out_illegal = m_ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 32-bit instance (2-bit counter) and a 64-bit instance
// driven by the same inputs, checked against hand-computed vectors.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [24:0] in_instr = '0;
  logic [2:0]  in_imm_src = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic [1:0]  cnt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;
  logic [7:0]  cnt64;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned exp_c32 = 0;
  int unsigned exp_c64 = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
    .out_illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
    .out_illegal(ill64), .illegal_cnt(cnt64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    in_instr   = v.instr[31:7];
    in_imm_src = v.src;
    in_tag     = v.tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{32'hFFF00093, 3'b000, 5'd3,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tv[1]  = '{32'hFE000EE3, 3'b011, 5'd4,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tv[2]  = '{32'hFF9FF06F, 3'b100, 5'd5,  32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    tv[3]  = '{32'h123450B7, 3'b001, 5'd6,  32'h12345000, 64'h0000000012345000, 1'b0};
    tv[4]  = '{32'h00F02073, 3'b110, 5'd7,  32'h00000000, 64'h0000000000000000, 1'b0};
    tv[5]  = '{32'h800000B7, 3'b001, 5'd8,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tv[6]  = '{32'h80000093, 3'b101, 5'd9,  32'h00000800, 64'h0000000000000800, 1'b0};
    tv[7]  = '{32'hFE112E23, 3'b010, 5'd10, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tv[8]  = '{32'h7FF00093, 3'b000, 5'd11, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    tv[9]  = '{32'hFFFFFFFF, 3'b111, 5'd12, 32'h00000000, 64'h0000000000000000, 1'b1};
    tv[10] = '{32'hFFFFFFFF, 3'b111, 5'd13, 32'h00000000, 64'h0000000000000000, 1'b1};
    tv[11] = '{32'h12345678, 3'b111, 5'd14, 32'h00000000, 64'h0000000000000000, 1'b1};
    tv[12] = '{32'h80000000, 3'b111, 5'd15, 32'h00000000, 64'h0000000000000000, 1'b1};
    tv[13] = '{32'hFFFFFFFF, 3'b111, 5'd31, 32'h00000000, 64'h0000000000000000, 1'b1};

    // Reset state
    #12;
    chk("rst_in_ready", {63'b0, rdy32}, 64'd0);
    chk("rst_out_valid", {63'b0, vld32}, 64'd0);
    chk("rst_cnt", {62'b0, cnt32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready32", {63'b0, rdy32}, 64'd1);
    chk("post_rst_in_ready64", {63'b0, rdy64}, 64'd1);

    // Streaming vectors with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tv[i]);
      chk($sformatf("v%0d_in_ready", i), {63'b0, rdy32}, 64'd1);
      tick();
      if (tv[i].ill) begin
        if (exp_c32 < 3) exp_c32++;
        exp_c64++;
      end
      chk($sformatf("v%0d_valid32", i), {63'b0, vld32}, 64'd1);
      chk($sformatf("v%0d_imm32", i), {32'b0, imm32}, {32'b0, tv[i].e32});
      chk($sformatf("v%0d_tag32", i), {59'b0, tag32}, {59'b0, tv[i].tag});
      chk($sformatf("v%0d_ill32", i), {63'b0, ill32}, {63'b0, tv[i].ill});
      chk($sformatf("v%0d_cnt32", i), {62'b0, cnt32}, 64'(exp_c32));
      chk($sformatf("v%0d_valid64", i), {63'b0, vld64}, 64'd1);
      chk($sformatf("v%0d_imm64", i), imm64, tv[i].e64);
      chk($sformatf("v%0d_cnt64", i), {56'b0, cnt64}, 64'(exp_c64));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'b0, vld32}, 64'd0);

    // Backpressure: A accepted, B into skid, C held off
    out_ready = 1'b0;
    drive(tv[0]);
    tick();
    chk("bp_A_out", {32'b0, imm32}, {32'b0, tv[0].e32});
    chk("bp_rdy_after_A", {63'b0, rdy32}, 64'd1);
    drive(tv[3]);
    tick();
    chk("bp_rdy_after_B", {63'b0, rdy32}, 64'd0);
    chk("bp_A_stable1", {32'b0, imm32}, {32'b0, tv[0].e32});
    drive(tv[8]);
    tick();
    chk("bp_A_stable2", {32'b0, imm32}, {32'b0, tv[0].e32});
    chk("bp_A_tag_stable", {59'b0, tag32}, {59'b0, tv[0].tag});
    chk("bp_rdy_stall", {63'b0, rdy32}, 64'd0);
    chk("bp_valid_stall", {63'b0, vld32}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_B_out", {32'b0, imm32}, {32'b0, tv[3].e32});
    chk("bp_B_tag", {59'b0, tag32}, {59'b0, tv[3].tag});
    chk("bp_rdy_reopen", {63'b0, rdy32}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_C_out", {32'b0, imm32}, {32'b0, tv[8].e32});
    chk("bp_C_valid", {63'b0, vld32}, 64'd1);
    tick();
    chk("bp_empty", {63'b0, vld32}, 64'd0);
    chk("bp_cnt_unchanged", {62'b0, cnt32}, 64'(exp_c32));

    // Mid-stall asynchronous reset with both entries full
    out_ready = 1'b0;
    drive(tv[5]);
    tick();
    drive(tv[9]);
    tick();
    in_valid = 1'b0;
    chk("fill_rdy", {63'b0, rdy64}, 64'd0);
    chk("fill_cnt64", {56'b0, cnt64}, 64'(exp_c64 + 1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'b0, vld64}, 64'd0);
    chk("ar_imm", imm64, 64'd0);
    chk("ar_tag", {59'b0, tag64}, 64'd0);
    chk("ar_ill", {63'b0, ill64}, 64'd0);
    chk("ar_cnt", {56'b0, cnt64}, 64'd0);
    chk("ar_rdy", {63'b0, rdy64}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rdy_before_edge", {63'b0, rdy32}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("ar_rdy_after_edge", {63'b0, rdy32}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ar_no_stale%0d", c), {62'b0, vld32, vld64}, 64'd0);
      tick();
    end
    chk("ar_cnt32_final", {62'b0, cnt32}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
